// File: rtl/tap_pkg.sv
// tap_pkg: nominal TAP timing, default tolerances, pulse classes and recorder states
package tap_pkg;
    localparam int T_PILOT      = 2168;
    localparam int T_SYNC1      = 667;
    localparam int T_SYNC2      = 735;
    localparam int T_BIT0       = 855;
    localparam int T_BIT1       = 1710;
    localparam int N_PILOT_HDR  = 8064;
    localparam int N_PILOT_DATA = 3224;
    localparam int D_PILOT_MIN  = 1900;
    localparam int D_PILOT_MAX  = 2500;
    localparam int D_PILOT_CNT  = 256;
    localparam int D_SYNC_MIN   = 550;
    localparam int D_SYNC_MAX   = 850;
    localparam int D_BIT0_MIN   = 600;
    localparam int D_BIT_SPLIT  = 1280;
    localparam int D_BIT1_MAX   = 2000;
    localparam int D_TIMEOUT    = 10500;
    typedef enum logic [2:0] {C_NONE, C_PILOT, C_SYNC, C_B0, C_B1, C_BAD} pclass_t;
    typedef enum logic [2:0] {S_HUNT, S_PILOT, S_SYNC2, S_DATA_H1, S_DATA_H2, S_CLOSE, S_LEN_HI} state_t;
    function automatic logic in_range(input logic [13:0] w, input int lo, input int hi);
        return int'(w) >= lo && int'(w) <= hi;
    endfunction
endpackage

// File: rtl/tap_pulse_meter.sv
// tap_pulse_meter: ear synchroniser, half-period width counter, timeout and pulse classifier
module tap_pulse_meter
    import tap_pkg::*;
#(
    parameter int PILOT_MIN = D_PILOT_MIN,
    parameter int PILOT_MAX = D_PILOT_MAX,
    parameter int SYNC_MIN  = D_SYNC_MIN,
    parameter int SYNC_MAX  = D_SYNC_MAX,
    parameter int BIT0_MIN  = D_BIT0_MIN,
    parameter int BIT_SPLIT = D_BIT_SPLIT,
    parameter int BIT1_MAX  = D_BIT1_MAX,
    parameter int TIMEOUT   = D_TIMEOUT
) (
    input  logic    clock,
    input  logic    reset_n,
    input  logic    ear,
    output logic    strobe,
    output logic    timeout,
    output pclass_t cls_lock,
    output pclass_t cls_data
);
    logic [2:0]  sync;
    logic [13:0] width;
    assign strobe = sync[2] ^ sync[1];
    assign timeout = !strobe && width == 14'(TIMEOUT);
    // pilot/sync view for locking; bit view (bits win the pilot/bit-1 overlap) inside a block
    assign cls_lock = !strobe ? C_NONE :
                      in_range(width, PILOT_MIN, PILOT_MAX) ? C_PILOT :
                      in_range(width, SYNC_MIN, SYNC_MAX) ? C_SYNC : C_BAD;
    assign cls_data = !strobe ? C_NONE :
                      in_range(width, BIT0_MIN, BIT_SPLIT - 1) ? C_B0 :
                      in_range(width, BIT_SPLIT, BIT1_MAX) ? C_B1 :
                      in_range(width, PILOT_MIN, PILOT_MAX) ? C_PILOT : C_BAD;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            sync  <= '0;
            width <= '0;
        end else begin
            sync  <= {sync[1:0], ear};
            width <= strobe ? 14'd1 : (&width ? width : width + 14'd1);
        end
endmodule

// File: rtl/tap_rec.sv
// tap_rec: TAP recorder, decodes ear half-periods into blocks written back in TAP layout
module tap_rec
    import tap_pkg::*;
#(
    parameter int PILOT_MIN = D_PILOT_MIN,
    parameter int PILOT_MAX = D_PILOT_MAX,
    parameter int PILOT_CNT = D_PILOT_CNT,
    parameter int SYNC_MIN  = D_SYNC_MIN,
    parameter int SYNC_MAX  = D_SYNC_MAX,
    parameter int BIT0_MIN  = D_BIT0_MIN,
    parameter int BIT_SPLIT = D_BIT_SPLIT,
    parameter int BIT1_MAX  = D_BIT1_MAX,
    parameter int TIMEOUT   = D_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ear,
    output logic [14:0] wr_address,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        block_done,
    output logic        error
);
    localparam int PCW = $clog2(PILOT_CNT + 1);
    logic           strobe, timeout;
    pclass_t        cls_lock, cls_data;
    state_t         st, st_n;
    logic [PCW-1:0] pcnt, pcnt_n;
    logic [2:0]     bitn, bitn_n;
    logic [15:0]    len, len_n;
    logic [7:0]     shreg, shreg_n, wd_n;
    logic [14:0]    base, base_n, wa_n;
    logic           h1, h1_n, pil, pil_n, busy_n, err_n, we_n, done_n;
    tap_pulse_meter #(
        .PILOT_MIN(PILOT_MIN), .PILOT_MAX(PILOT_MAX), .SYNC_MIN(SYNC_MIN), .SYNC_MAX(SYNC_MAX),
        .BIT0_MIN(BIT0_MIN), .BIT_SPLIT(BIT_SPLIT), .BIT1_MAX(BIT1_MAX), .TIMEOUT(TIMEOUT)
    ) u_meter (
        .clock(clock), .reset_n(reset_n), .ear(ear), .strobe(strobe),
        .timeout(timeout), .cls_lock(cls_lock), .cls_data(cls_data)
    );
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            st <= S_HUNT;
            pcnt <= '0;
            bitn <= 3'd7;
            len <= '0;
            shreg <= '0;
            base <= '0;
            h1 <= 1'b0;
            pil <= 1'b0;
            busy <= 1'b0;
            error <= 1'b0;
            wr_en <= 1'b0;
            wr_address <= '0;
            wr_data <= '0;
            block_done <= 1'b0;
        end else begin
            st <= st_n;
            pcnt <= pcnt_n;
            bitn <= bitn_n;
            len <= len_n;
            shreg <= shreg_n;
            base <= base_n;
            h1 <= h1_n;
            pil <= pil_n;
            busy <= busy_n;
            error <= err_n;
            wr_en <= we_n;
            wr_address <= wa_n;
            wr_data <= wd_n;
            block_done <= done_n;
        end
    always_comb begin
        st_n = st;
        pcnt_n = pcnt;
        bitn_n = bitn;
        len_n = len;
        shreg_n = shreg;
        base_n = base;
        h1_n = h1;
        pil_n = pil;
        busy_n = busy;
        err_n = error;
        we_n = 1'b0;
        wa_n = wr_address;
        wd_n = wr_data;
        done_n = 1'b0;
        case (st)
            S_HUNT: if (cls_lock == C_PILOT) begin
                st_n = S_PILOT;
                pcnt_n = PCW'(1);
            end
            S_PILOT:
                if (cls_lock == C_PILOT) pcnt_n = (pcnt == PCW'(PILOT_CNT)) ? pcnt : pcnt + 1'b1;
                else if (cls_lock == C_SYNC && pcnt == PCW'(PILOT_CNT)) st_n = S_SYNC2;
                else if (strobe || timeout) st_n = S_HUNT;
            S_SYNC2:
                if (cls_lock == C_SYNC) begin
                    st_n = S_DATA_H1;
                    busy_n = 1'b1;
                    err_n = 1'b0;
                    bitn_n = 3'd7;
                    len_n = '0;
                end else if (strobe || timeout) st_n = S_HUNT;
            S_DATA_H1:
                if (cls_data == C_B0 || cls_data == C_B1) begin
                    h1_n = cls_data == C_B1;
                    st_n = S_DATA_H2;
                end else if (strobe || timeout) begin
                    pil_n = cls_data == C_PILOT;
                    st_n = S_CLOSE;
                end
            S_DATA_H2:
                if (timeout) begin
                    err_n = 1'b1;
                    pil_n = 1'b0;
                    st_n = S_CLOSE;
                end else if (strobe && cls_data == (h1 ? C_B1 : C_B0)) begin
                    // bitn wraps 0 -> 7, re-arming the next byte
                    shreg_n = {shreg[6:0], h1};
                    bitn_n = bitn - 3'd1;
                    st_n = S_DATA_H1;
                    if (bitn == 3'd0) begin
                        we_n = 1'b1;
                        wa_n = base + 15'd2 + len[14:0];
                        wd_n = {shreg[6:0], h1};
                        len_n = len + 16'd1;
                    end
                end else if (strobe) begin
                    err_n = 1'b1;
                    busy_n = 1'b0;
                    st_n = S_HUNT;
                end
            S_CLOSE: begin
                err_n = error | (bitn != 3'd7);
                if (len == 16'd0) begin
                    busy_n = 1'b0;
                    st_n = S_HUNT;
                end else begin
                    we_n = 1'b1;
                    wa_n = base;
                    wd_n = len[7:0];
                    st_n = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                we_n = 1'b1;
                wa_n = base + 15'd1;
                wd_n = len[15:8];
                done_n = 1'b1;
                base_n = base + 15'd2 + len[14:0];
                busy_n = 1'b0;
                pcnt_n = PCW'(1);
                st_n = pil ? S_PILOT : S_HUNT;
            end
            default: st_n = S_HUNT;
        endcase
    end
endmodule
